// File: rtl/wave_buffer_writer_pkg.sv
// Shared definitions for the ECG waveform capture writer: sample width and FSM encoding.
package wave_buffer_writer_pkg;

    localparam int SAMPLE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_HOLD  = 3'd4
    } wb_state_t;

endpackage

// File: rtl/wave_trigger_detect.sv
// Rising-crossing detector: remembers the previous qualifying sample and flags
// prev < trig_level <= sample once at least one sample has been seen since clear.
module wave_trigger_detect
    import wave_buffer_writer_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                qual,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic [SAMPLE_W-1:0] trig_level,
    output logic [SAMPLE_W-1:0] prev,
    output logic                prev_valid,
    output logic                crossing
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev       <= '0;
            prev_valid <= 1'b0;
        end else if (clear) begin
            prev_valid <= 1'b0;
        end else if (qual) begin
            prev       <= sample;
            prev_valid <= 1'b1;
        end
    end

    assign crossing = prev_valid && (prev < trig_level) && (sample >= trig_level);

endmodule

// File: rtl/wave_buffer_writer.sv
// Pre/post-trigger capture of decimated ECG samples into a circular BRAM.
// Optional build macro WAVE_BUFFER_AVG_EN writes the rounded mean of the previous and current sample.
module wave_buffer_writer
    import wave_buffer_writer_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int PRE_TRIG   = 512,
    parameter int DECIM      = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [SAMPLE_W-1:0]   sample_in,
    input  logic                  sample_valid,
    input  logic                  arm,
    input  logic                  force_trig,
    input  logic [SAMPLE_W-1:0]   trig_level,
    output logic                  wr_en,
    output logic [DEPTH_LOG2-1:0] wr_adr,
    output logic [SAMPLE_W-1:0]   wr_data,
    output logic [DEPTH_LOG2-1:0] display_base,
    output logic                  capture_done,
    output logic [2:0]            state
);

    localparam int                    DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PRE_LAST  = DEPTH_LOG2'(PRE_TRIG - 1);
    localparam logic [DEPTH_LOG2-1:0] POST_LAST = DEPTH_LOG2'(DEPTH - PRE_TRIG - 1);
    localparam logic [DEPTH_LOG2-1:0] PRE_OFS   = DEPTH_LOG2'(PRE_TRIG);
    localparam logic [7:0]            DEC_LAST  = 8'(DECIM - 1);

    wb_state_t             state_q, state_d;
    logic [7:0]            dec_cnt;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] wcnt;
    logic                  force_pend;
    logic                  capturing, qual, trig, crossing, prev_valid;
    logic [SAMPLE_W-1:0]   prev, data_out;

    // arm has priority over a coincident sample: the restart discards it.
    assign capturing = (state_q == ST_FILL) || (state_q == ST_ARMED) || (state_q == ST_POST);
    assign qual      = capturing && sample_valid && !arm && (dec_cnt == DEC_LAST);
    assign trig      = (state_q == ST_ARMED) && qual && (crossing || force_trig || force_pend);

    wave_trigger_detect u_trig (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (arm),
        .qual       (qual),
        .sample     (sample_in),
        .trig_level (trig_level),
        .prev       (prev),
        .prev_valid (prev_valid),
        .crossing   (crossing)
    );

`ifdef WAVE_BUFFER_AVG_EN
    logic [SAMPLE_W:0] avg_full;
    logic              unused_avg_lsb;
    assign avg_full       = {1'b0, prev} + {1'b0, sample_in} + 9'd1;
    assign unused_avg_lsb = avg_full[0];
    assign data_out       = prev_valid ? avg_full[SAMPLE_W:1] : sample_in;
`else
    logic unused_prev;
    assign unused_prev = ^{prev, prev_valid};
    assign data_out    = sample_in;
`endif

    always_comb begin
        state_d = state_q;
        if (arm) begin
            state_d = ST_FILL;
        end else begin
            case (state_q)
                ST_FILL:  if (qual && wcnt == PRE_LAST) state_d = ST_ARMED;
                ST_ARMED: if (trig) state_d = (POST_LAST == '0) ? ST_HOLD : ST_POST;
                ST_POST:  if (qual && wcnt == POST_LAST) state_d = ST_HOLD;
                default:  state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            dec_cnt      <= '0;
            wr_ptr       <= '0;
            wcnt         <= '0;
            force_pend   <= 1'b0;
            wr_en        <= 1'b0;
            wr_adr       <= '0;
            wr_data      <= '0;
            display_base <= '0;
        end else begin
            state_q <= state_d;
            wr_en   <= qual;
            if (qual) begin
                wr_adr  <= wr_ptr;
                wr_data <= data_out;
                wr_ptr  <= wr_ptr + 1'b1;
            end
            if (arm) begin
                dec_cnt    <= '0;
                wcnt       <= '0;
                force_pend <= 1'b0;
            end else begin
                if (capturing && sample_valid)
                    dec_cnt <= (dec_cnt == DEC_LAST) ? 8'd0 : dec_cnt + 8'd1;
                // The trigger write is the first of the post-trigger writes.
                if (trig)
                    wcnt <= DEPTH_LOG2'(1);
                else if (qual)
                    wcnt <= wcnt + 1'b1;
                if (state_q != ST_ARMED || trig)
                    force_pend <= 1'b0;
                else if (force_trig)
                    force_pend <= 1'b1;
                if (trig)
                    display_base <= wr_ptr - PRE_OFS;
            end
        end
    end

    assign capture_done = (state_q == ST_HOLD);
    assign state        = state_q;

endmodule

// File: tb/tb_wave_buffer_writer.sv
// Directed bench for wave_buffer_writer: ramp capture table plus hand-written
// sequences for force trigger, restart, reset mid-capture and decimation.
module tb_wave_buffer_writer;
    import wave_buffer_writer_pkg::*;

    logic       clk, reset_n;
    logic [7:0] sample_in, trig_level;
    logic       sample_valid, arm, force_trig;
    logic       wr_en, capture_done, wr_en3, capture_done3;
    logic [3:0] wr_adr, display_base, wr_adr3, display_base3;
    logic [7:0] wr_data, wr_data3;
    logic [2:0] state, state3;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] s;
        logic       exp_wr;
        logic [3:0] exp_adr;
        logic [2:0] exp_st;
    } vec_t;

    vec_t tab [32];

    wave_buffer_writer #(.DEPTH_LOG2(4), .PRE_TRIG(4), .DECIM(1)) dut (
        .clk(clk), .reset_n(reset_n), .sample_in(sample_in), .sample_valid(sample_valid),
        .arm(arm), .force_trig(force_trig), .trig_level(trig_level),
        .wr_en(wr_en), .wr_adr(wr_adr), .wr_data(wr_data),
        .display_base(display_base), .capture_done(capture_done), .state(state)
    );

    wave_buffer_writer #(.DEPTH_LOG2(4), .PRE_TRIG(4), .DECIM(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .sample_in(sample_in), .sample_valid(sample_valid),
        .arm(arm), .force_trig(force_trig), .trig_level(trig_level),
        .wr_en(wr_en3), .wr_adr(wr_adr3), .wr_data(wr_data3),
        .display_base(display_base3), .capture_done(capture_done3), .state(state3)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_check(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("wr_en_idle", wr_en, 0);
        end
    endtask

    // One sample strobe, check the write one cycle later, then three quiet cycles.
    task automatic send(input logic [7:0] s, input logic frc, input logic exp_wr,
                        input logic [3:0] exp_adr, input logic [7:0] exp_data,
                        input logic [2:0] exp_st, input string name);
        sample_in = s; sample_valid = 1'b1; force_trig = frc;
        @(negedge clk);
        sample_valid = 1'b0; force_trig = 1'b0;
        chk({name, "_wr_en"}, wr_en, exp_wr);
        if (exp_wr) begin
            chk({name, "_wr_adr"}, wr_adr, exp_adr);
            chk({name, "_wr_data"}, wr_data, exp_data);
        end
        chk({name, "_state"}, state, exp_st);
        idle_check(3);
    endtask

    task automatic do_arm();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        chk("arm_state", state, ST_FILL);
        chk("arm_done_low", capture_done, 0);
    endtask

    task automatic pulse_force(input logic [2:0] exp_st);
        force_trig = 1'b1;
        @(negedge clk);
        force_trig = 1'b0;
        chk("force_wr_en", wr_en, 0);
        chk("force_state", state, exp_st);
    endtask

    initial begin
        logic [7:0] exp_d;
        logic [7:0] dec_exp [3];
`ifdef WAVE_BUFFER_AVG_EN
        dec_exp = '{8'd3, 8'd5, 8'd8};
`else
        dec_exp = '{8'd3, 8'd6, 8'd9};
`endif
        for (int i = 0; i < 32; i++) begin
            tab[i].s       = 8'(i);
            tab[i].exp_wr  = (i <= 21);
            tab[i].exp_adr = 4'(i);
            tab[i].exp_st  = (i < 3) ? ST_FILL : (i < 10) ? ST_ARMED : (i < 21) ? ST_POST : ST_HOLD;
        end

        reset_n = 1'b0; sample_in = '0; sample_valid = 1'b0; arm = 1'b0;
        force_trig = 1'b0; trig_level = 8'd10;
        repeat (3) @(negedge clk);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_adr", wr_adr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_display_base", display_base, 0);
        chk("rst_capture_done", capture_done, 0);
        chk("rst_state", state, ST_IDLE);
        reset_n = 1'b1;
        @(negedge clk);

        send(8'd5, 1'b0, 1'b0, 4'd0, 8'd0, ST_IDLE, "idle_sample");

        // Ramp capture: trigger on sample 10, hold after sample 21.
        do_arm();
        for (int i = 0; i < 32; i++)
            send(tab[i].s, 1'b0, tab[i].exp_wr, tab[i].exp_adr, tab[i].s, tab[i].exp_st, "ramp");
        chk("ramp_display_base", display_base, 6);
        chk("ramp_capture_done", capture_done, 1);

        // Constant above level never crosses; force in FILL ignored, in ARMED arms the next sample.
        trig_level = 8'd100;
        do_arm();
        send(8'd200, 1'b0, 1'b1, 4'd6, 8'd200, ST_FILL, "const");
        pulse_force(ST_FILL);
        send(8'd200, 1'b1, 1'b1, 4'd7, 8'd200, ST_FILL, "const");
        send(8'd200, 1'b0, 1'b1, 4'd8, 8'd200, ST_FILL, "const");
        send(8'd200, 1'b0, 1'b1, 4'd9, 8'd200, ST_ARMED, "const");
        for (int k = 10; k < 13; k++)
            send(8'd200, 1'b0, 1'b1, 4'(k), 8'd200, ST_ARMED, "const_armed");
        pulse_force(ST_ARMED);
        idle_check(2);
`ifdef WAVE_BUFFER_AVG_EN
        exp_d = 8'd125;
`else
        exp_d = 8'd50;
`endif
        send(8'd50, 1'b0, 1'b1, 4'd13, exp_d, ST_POST, "forced");
        chk("forced_display_base", display_base, 9);

        // Restart during POST: pointer continues, pre-count restarts.
`ifdef WAVE_BUFFER_AVG_EN
        exp_d = 8'd125;
`else
        exp_d = 8'd200;
`endif
        send(8'd200, 1'b0, 1'b1, 4'd14, exp_d, ST_POST, "post");
        send(8'd200, 1'b0, 1'b1, 4'd15, 8'd200, ST_POST, "post");
        do_arm();
        send(8'd200, 1'b0, 1'b1, 4'd0, 8'd200, ST_FILL, "refill");
        send(8'd200, 1'b0, 1'b1, 4'd1, 8'd200, ST_FILL, "refill");
        send(8'd200, 1'b0, 1'b1, 4'd2, 8'd200, ST_FILL, "refill");
        send(8'd200, 1'b0, 1'b1, 4'd3, 8'd200, ST_ARMED, "refill");
        chk("refill_display_base", display_base, 9);

        // Forced trigger with sample, then reset while the write strobe is high.
        sample_in = 8'd200; sample_valid = 1'b1; force_trig = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0; force_trig = 1'b0;
        chk("pre_reset_wr_en", wr_en, 1);
        chk("pre_reset_wr_adr", wr_adr, 4);
        chk("pre_reset_state", state, ST_POST);
        #2 reset_n = 1'b0;
        #1;
        chk("async_wr_en", wr_en, 0);
        chk("async_wr_adr", wr_adr, 0);
        chk("async_wr_data", wr_data, 0);
        chk("async_display_base", display_base, 0);
        chk("async_capture_done", capture_done, 0);
        chk("async_state", state, ST_IDLE);
        @(negedge clk);
        reset_n = 1'b1;
        send(8'd7, 1'b0, 1'b0, 4'd0, 8'd0, ST_IDLE, "after_reset");

        // Decimation by 3 on the second instance.
        do_arm();
        for (int k = 1; k <= 9; k++) begin
            sample_in = 8'(k); sample_valid = 1'b1;
            @(negedge clk);
            sample_valid = 1'b0;
            chk("dec_wr_en", wr_en3, (k % 3 == 0));
            if (k % 3 == 0) begin
                chk("dec_wr_adr", wr_adr3, k / 3 - 1);
                chk("dec_wr_data", wr_data3, dec_exp[k / 3 - 1]);
            end
            chk("dec_state", state3, ST_FILL);
            repeat (3) begin
                @(negedge clk);
                chk("dec_wr_idle", wr_en3, 0);
            end
        end

`ifdef WAVE_BUFFER_AVG_EN
        do_arm();
        send(8'd10, 1'b0, 1'b1, 4'd9, 8'd10, ST_FILL, "avg");
        send(8'd21, 1'b0, 1'b1, 4'd10, 8'd16, ST_FILL, "avg");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
